// File: rtl/wrr_hold_arbiter.sv
// Weighted round-robin arbiter that holds each grant for a whole transaction.
// Define WRR_WATCHDOG_EN to force-revoke grants held for MAXHOLD cycles.
module wrr_hold_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WW      = 3,
    parameter int unsigned MAXHOLD = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ-1:0]         rel_i,
    input  logic [NREQ*WW-1:0]      weight_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [$clog2(NREQ)-1:0] gnt_id_o,
    output logic                    busy_o,
    output logic                    timeout_o
);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic {IDLE, GRANT} state_e;

    if (NREQ < 2 || NREQ > 8 || MAXHOLD < 2 || WW < 1) begin : g_param_check
        $error("wrr_hold_arbiter: unsupported parameter set");
    end

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [IW-1:0]   gnt_id_q;
    logic [IW-1:0]   ptr_q;
    logic [WW-1:0]   credit_q;
    logic            busy_q;

    logic [WW-1:0]   wt_c [NREQ];
    logic [IW-1:0]   arb_base_c;
    logic [IW-1:0]   arb_idx_c;
    logic            arb_found_c;
    logic [WW-1:0]   credit_load_c;
    logic [WW-1:0]   credit_dec_c;
    logic            own_req_c;
    logic            own_rel_c;
    logic            wd_c;
    logic            end_c;
    logic            regrant_c;
    logic            rotate_c;
    logic            load_c;
    logic            go_idle_c;

    for (genvar g = 0; g < NREQ; g++) begin : g_wt
        assign wt_c[g] = weight_i[g*WW +: WW];
    end

    assign own_req_c = req_i[gnt_id_q];
    assign own_rel_c = rel_i[gnt_id_q];

`ifdef WRR_WATCHDOG_EN
    localparam int unsigned HW = $clog2(MAXHOLD);

    logic [HW-1:0] hold_cnt_q;
    logic          timeout_q;

    assign wd_c = (state_q == GRANT) && (hold_cnt_q == HW'(MAXHOLD - 1))
                  && own_req_c && !own_rel_c;
    assign timeout_o = timeout_q;
`else
    assign wd_c      = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Rotation base: last owner at the end of a transaction, saved pointer otherwise.
    assign arb_base_c = (state_q == GRANT) ? gnt_id_q : ptr_q;

    always_comb begin
        int unsigned idx;
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        idx         = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(arb_base_c) + k) % NREQ;
            if (!arb_found_c && req_i[IW'(idx)]) begin
                arb_found_c = 1'b1;
                arb_idx_c   = IW'(idx);
            end
        end
    end

    assign credit_load_c = (wt_c[arb_idx_c] == '0) ? WW'(1) : wt_c[arb_idx_c];
    assign credit_dec_c  = credit_q - WW'(1);

    assign end_c     = (state_q == GRANT) && (own_rel_c || !own_req_c || wd_c);
    assign regrant_c = end_c && (credit_dec_c != '0) && own_req_c && !wd_c;
    assign rotate_c  = end_c && !regrant_c;
    assign load_c    = arb_found_c && ((state_q == IDLE) || rotate_c);
    assign go_idle_c = rotate_c && !arb_found_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_id_q   <= '0;
            ptr_q      <= IW'(NREQ - 1);
            credit_q   <= '0;
            busy_q     <= 1'b0;
`ifdef WRR_WATCHDOG_EN
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
`ifdef WRR_WATCHDOG_EN
            timeout_q <= wd_c;
`endif
            if (rotate_c) begin
                ptr_q <= gnt_id_q;
            end
            if (load_c) begin
                state_q    <= GRANT;
                gnt_q      <= NREQ'(1) << arb_idx_c;
                gnt_id_q   <= arb_idx_c;
                busy_q     <= 1'b1;
                credit_q   <= credit_load_c;
`ifdef WRR_WATCHDOG_EN
                hold_cnt_q <= '0;
`endif
            end else if (go_idle_c) begin
                state_q  <= IDLE;
                gnt_q    <= '0;
                busy_q   <= 1'b0;
                credit_q <= '0;
            end else if (regrant_c) begin
                credit_q   <= credit_dec_c;
`ifdef WRR_WATCHDOG_EN
                hold_cnt_q <= '0;
`endif
            end
`ifdef WRR_WATCHDOG_EN
            else if (state_q == GRANT && hold_cnt_q != HW'(MAXHOLD - 1)) begin
                hold_cnt_q <= hold_cnt_q + HW'(1);
            end
`endif
        end
    end

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gnt_id_q;
    assign busy_o   = busy_q;

endmodule
